param_sync_fifo: RTL

//  Single-clock FIFO with parametrised width/depth, water-level output, programmable

---
 rtl/param_sync_fifo.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with water level, almost-full/empty thresholds, overflow/underflow pulses
// and optional first-word-fall-through read; define PSF_ERR_CNT_EN to add rejection counters.
module param_sync_fifo #(
    parameter int DATA_W  = 8,
    parameter int DEPTH_W = 11,
    parameter int AF_NUM  = 1460,
    parameter int AE_NUM  = 4,
    parameter int FWFT    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_full,
    output logic              almost_full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_empty,
    output logic              almost_empty,
    output logic [DEPTH_W:0]  water_level,
    output logic              overflow,
    output logic              underflow
`ifdef PSF_ERR_CNT_EN
    ,
    output logic [15:0]       wr_err_cnt,
    output logic [15:0]       rd_err_cnt
`endif
);

    localparam logic [DEPTH_W:0] LP_ONE  = {{DEPTH_W{1'b0}}, 1'b1};
    localparam logic [DEPTH_W:0] LP_ZERO = '0;
    localparam logic [DEPTH_W:0] LP_FULL = {1'b1, {DEPTH_W{1'b0}}};
    localparam logic [DEPTH_W:0] LP_AF   = (DEPTH_W+1)'(AF_NUM);
    localparam logic [DEPTH_W:0] LP_AE   = (DEPTH_W+1)'(AE_NUM);

    // Output-register occupancy; only leaves ST_EMPTY in FWFT mode.
    typedef enum logic {ST_EMPTY, ST_VALID} fwft_state_t;

    logic [DATA_W-1:0] r_mem [0:(1<<DEPTH_W)-1];
    logic [DEPTH_W:0]  r_wr_ptr;
    logic [DEPTH_W:0]  r_rd_ptr;
    logic [DEPTH_W:0]  r_level;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_full;
    logic              r_empty;
    logic              r_af;
    logic              r_ae;
    logic              r_overflow;
    logic              r_underflow;
    fwft_state_t       r_state;

    fwft_state_t       w_state_next;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_mem_rd;
    logic              w_mem_avail;
    logic [DEPTH_W:0]  w_mem_cnt;
    logic [DEPTH_W:0]  w_level_next;
    logic              w_empty_next;

    assign w_wr_acc    = wr_en & ~r_full;
    assign w_rd_acc    = rd_en & ~r_empty;
    assign w_mem_cnt   = r_wr_ptr - r_rd_ptr;
    assign w_mem_avail = (w_mem_cnt != LP_ZERO);

    always_comb begin
        w_state_next = r_state;
        w_mem_rd     = w_rd_acc;
        if (FWFT != 0) begin
            // Memory is read to refill the output register whenever it is or becomes free.
            w_mem_rd = 1'b0;
            case (r_state)
                ST_EMPTY: begin
                    if (w_mem_avail) begin
                        w_mem_rd     = 1'b1;
                        w_state_next = ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (w_rd_acc) begin
                        if (w_mem_avail) w_mem_rd = 1'b1;
                        else             w_state_next = ST_EMPTY;
                    end
                end
                default: w_state_next = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        w_level_next = r_level;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_level_next = r_level + LP_ONE;
            2'b01:   w_level_next = r_level - LP_ONE;
            default: w_level_next = r_level;
        endcase
        w_empty_next = (FWFT != 0) ? (w_state_next == ST_EMPTY) : (w_level_next == LP_ZERO);
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc && !clr) r_mem[r_wr_ptr[DEPTH_W-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_rd_data   <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_af        <= 1'b0;
            r_ae        <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_state     <= ST_EMPTY;
        end else if (clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_af        <= 1'b0;
            r_ae        <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_state     <= ST_EMPTY;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + LP_ONE;
            if (w_mem_rd) begin
                r_rd_ptr  <= r_rd_ptr + LP_ONE;
                r_rd_data <= r_mem[r_rd_ptr[DEPTH_W-1:0]];
            end
            r_level     <= w_level_next;
            r_full      <= (w_level_next == LP_FULL);
            r_empty     <= w_empty_next;
            r_af        <= (w_level_next >= LP_AF);
            r_ae        <= (w_level_next <= LP_AE);
            r_overflow  <= wr_en & r_full;
            r_underflow <= rd_en & r_empty;
            r_state     <= w_state_next;
        end
    end

`ifdef PSF_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_cnt <= '0;
            rd_err_cnt <= '0;
        end else if (clr) begin
            wr_err_cnt <= '0;
            rd_err_cnt <= '0;
        end else begin
            if (wr_en && r_full && (wr_err_cnt != 16'hFFFF))  wr_err_cnt <= wr_err_cnt + 16'd1;
            if (rd_en && r_empty && (rd_err_cnt != 16'hFFFF)) rd_err_cnt <= rd_err_cnt + 16'd1;
        end
    end
`endif

    assign wr_full      = r_full;
    assign almost_full  = r_af;
    assign rd_data      = r_rd_data;
    assign rd_empty     = r_empty;
    assign almost_empty = r_ae;
    assign water_level  = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
